// File: rtl/game_board_engine.sv
// 2048 game engine: owns the 4x4 board, applies slide/merge moves one line per cycle,
// spawns tiles from a 16-bit LFSR and tracks score, win and game-over status.
module game_board_engine #(
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          FOUR_ODDS_BITS = 4
) (
  input  logic         clk_50MHz_i,
  input  logic         reset_i,
  input  logic         move_valid_i,
  input  logic [1:0]   move_dir_i,
  output logic         move_ready_o,
  input  logic         load_en_i,
  input  logic [191:0] load_data_i,
  output logic [191:0] game_state_o,
  output logic [19:0]  score_o,
  output logic         game_won_o,
  output logic         game_over_o
);

  typedef enum logic [2:0] {
    S_INIT0, S_INIT1, S_IDLE, S_MOVE, S_SPAWN, S_CHECK, S_WON, S_OVER
  } state_t;

  state_t             state_q, state_d;
  logic [15:0][11:0]  board_q, board_d;
  logic [19:0]        score_q, score_d;
  logic               won_q, won_d;
  logic               over_q, over_d;
  logic               ready_q, ready_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [1:0]         line_q, line_d;
  logic [1:0]         dir_q, dir_d;
  logic               changed_q, changed_d;

  // Board index of position pos (0 = leading edge) on the given line for direction dir.
  function automatic logic [3:0] cell_idx(input logic [1:0] dir, input logic [1:0] line,
                                          input logic [1:0] pos);
    case (dir)
      2'd0:    cell_idx = {line, pos};
      2'd1:    cell_idx = {line, ~pos};
      2'd2:    cell_idx = {pos, line};
      default: cell_idx = {~pos, line};
    endcase
  endfunction

  logic [11:0] line_in  [4];
  logic [11:0] comp     [4];
  logic [11:0] line_out [4];
  logic [2:0]  comp_cnt;
  logic [12:0] line_gain;
  logic        line_changed;

  always_comb begin
    comp_cnt     = '0;
    line_gain    = '0;
    line_changed = 1'b0;
    for (int k = 0; k < 4; k++) begin
      line_in[k]  = board_q[cell_idx(dir_q, line_q, 2'(k))];
      comp[k]     = '0;
      line_out[k] = '0;
    end
    for (int k = 0; k < 4; k++) begin
      if (line_in[k] != '0) begin
        comp[comp_cnt[1:0]] = line_in[k];
        comp_cnt            = comp_cnt + 3'd1;
      end
    end
    // Leading pair merges first; a merged result never merges again in the same move.
    if (comp[0] != '0 && comp[0] == comp[1]) begin
      line_out[0] = {comp[0][10:0], 1'b0};
      if (comp[2] != '0 && comp[2] == comp[3]) begin
        line_out[1] = {comp[2][10:0], 1'b0};
      end else begin
        line_out[1] = comp[2];
        line_out[2] = comp[3];
      end
    end else if (comp[1] != '0 && comp[1] == comp[2]) begin
      line_out[0] = comp[0];
      line_out[1] = {comp[1][10:0], 1'b0};
      line_out[2] = comp[3];
    end else if (comp[2] != '0 && comp[2] == comp[3]) begin
      line_out[0] = comp[0];
      line_out[1] = comp[1];
      line_out[2] = {comp[2][10:0], 1'b0};
    end else begin
      for (int k = 0; k < 4; k++) line_out[k] = comp[k];
    end
    if (comp[0] != '0 && comp[0] == comp[1]) line_gain = line_gain + 13'(line_out[0]);
    if (line_out[1] != comp[1] || (comp[0] != comp[1] && comp[1] != '0 && comp[1] == comp[2]))
      line_gain = line_gain + ((comp[1] != '0 && comp[1] == comp[2] && comp[0] != comp[1])
                               ? 13'(line_out[1]) : 13'd0);
    if (comp[0] == comp[1] && comp[0] != '0 && comp[2] != '0 && comp[2] == comp[3])
      line_gain = line_gain + 13'(line_out[1]);
    if (comp[0] != comp[1] && comp[1] != comp[2] && comp[2] != '0 && comp[2] == comp[3])
      line_gain = line_gain + 13'(line_out[2]);
    for (int k = 0; k < 4; k++) begin
      if (line_out[k] != line_in[k]) line_changed = 1'b1;
    end
  end

  logic        spawn_found;
  logic [3:0]  spawn_idx;
  logic [3:0]  spawn_cand;
  logic [11:0] spawn_val;

  always_comb begin
    spawn_found = 1'b0;
    spawn_idx   = lfsr_q[3:0];
    spawn_cand  = lfsr_q[3:0];
    for (int k = 0; k < 16; k++) begin
      spawn_cand = lfsr_q[3:0] + 4'(k);
      if (!spawn_found && board_q[spawn_cand] == '0) begin
        spawn_found = 1'b1;
        spawn_idx   = spawn_cand;
      end
    end
    spawn_val = (lfsr_q[FOUR_ODDS_BITS+3:4] == '0) ? 12'd4 : 12'd2;
  end

  logic has_2048, has_empty, has_pair;

  always_comb begin
    has_2048  = 1'b0;
    has_empty = 1'b0;
    has_pair  = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (board_q[4'(r*4+c)] == 12'd2048) has_2048 = 1'b1;
        if (board_q[4'(r*4+c)] == '0) has_empty = 1'b1;
        if (c < 3 && board_q[4'(r*4+c)] == board_q[4'(r*4+c+1)]) has_pair = 1'b1;
        if (r < 3 && board_q[4'(r*4+c)] == board_q[4'((r+1)*4+c)]) has_pair = 1'b1;
      end
    end
  end

  logic [20:0] score_sum;
  assign score_sum = {1'b0, score_q} + 21'(line_gain);

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    score_d   = score_q;
    won_d     = won_q;
    over_d    = over_q;
    line_d    = line_q;
    dir_d     = dir_q;
    changed_d = changed_q;
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    case (state_q)
      S_INIT0, S_INIT1, S_SPAWN: begin
        if (spawn_found) board_d[spawn_idx] = spawn_val;
        state_d = (state_q == S_INIT0) ? S_INIT1 : S_CHECK;
      end
      S_IDLE: begin
        if (load_en_i) begin
          board_d = load_data_i;
          over_d  = 1'b0;
          state_d = S_CHECK;
        end else if (move_valid_i) begin
          dir_d     = move_dir_i;
          line_d    = 2'd0;
          changed_d = 1'b0;
          state_d   = S_MOVE;
        end
      end
      S_MOVE: begin
        for (int k = 0; k < 4; k++) board_d[cell_idx(dir_q, line_q, 2'(k))] = line_out[k];
        score_d   = score_sum[20] ? 20'hFFFFF : score_sum[19:0];
        changed_d = changed_q | line_changed;
        line_d    = line_q + 2'd1;
        if (line_q == 2'd3) state_d = (changed_q | line_changed) ? S_SPAWN : S_IDLE;
      end
      S_CHECK: begin
        won_d  = has_2048;
        over_d = over_q | (!has_empty && !has_pair);
        if (has_2048)                            state_d = S_WON;
        else if (over_q | (!has_empty && !has_pair)) state_d = S_OVER;
        else                                     state_d = S_IDLE;
      end
      default: ;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_50MHz_i) begin
    if (reset_i) begin
      state_q   <= S_INIT0;
      board_q   <= '0;
      score_q   <= '0;
      won_q     <= 1'b0;
      over_q    <= 1'b0;
      ready_q   <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      line_q    <= '0;
      dir_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      score_q   <= score_d;
      won_q     <= won_d;
      over_q    <= over_d;
      ready_q   <= ready_d;
      lfsr_q    <= lfsr_d;
      line_q    <= line_d;
      dir_q     <= dir_d;
      changed_q <= changed_d;
    end
  end

  assign move_ready_o = ready_q;
  assign game_state_o = board_q;
  assign score_o      = score_q;
  assign game_won_o   = won_q;
  assign game_over_o  = over_q;

endmodule

// File: tb/tb_game_board_engine.sv
// Directed bench for game_board_engine: init spawns, merges, no-op moves, win, game over
// and reset during a move, each checked against hand-computed boards and scores.
module tb_game_board_engine;

  logic         clk = 1'b0;
  logic         reset, move_valid, load_en;
  logic [1:0]   move_dir;
  logic [191:0] load_data;
  logic         move_ready, game_won, game_over;
  logic [191:0] game_state;
  logic [19:0]  score;

  int vectors     = 0;
  int miscompares = 0;
  int exp_score   = 0;

  always #10 clk = ~clk;

  game_board_engine dut (
    .clk_50MHz_i (clk),
    .reset_i     (reset),
    .move_valid_i(move_valid),
    .move_dir_i  (move_dir),
    .move_ready_o(move_ready),
    .load_en_i   (load_en),
    .load_data_i (load_data),
    .game_state_o(game_state),
    .score_o     (score),
    .game_won_o  (game_won),
    .game_over_o (game_over)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] tile(input logic [191:0] b, input int r, input int c);
    return b[(r*4+c)*12 +: 12];
  endfunction

  function automatic logic [191:0] put(input logic [191:0] b, input int r, input int c,
                                       input logic [11:0] v);
    logic [191:0] nb;
    nb = b;
    nb[(r*4+c)*12 +: 12] = v;
    return nb;
  endfunction

  function automatic int nz_count(input logic [191:0] b);
    int n = 0;
    for (int i = 0; i < 16; i++) if (b[i*12 +: 12] != 12'd0) n++;
    return n;
  endfunction

  function automatic int tile_sum(input logic [191:0] b);
    int s = 0;
    for (int i = 0; i < 16; i++) s += int'(b[i*12 +: 12]);
    return s;
  endfunction

  // Seed 16'hACE1 spawns a 2 at cell 1, then (lfsr 16'h59C3) a 2 at cell 3.
  function automatic logic [191:0] init_board();
    return put(put('0, 0, 1, 12'd2), 0, 3, 12'd2);
  endfunction

  task automatic issue_load(input logic [191:0] data, input logic with_move, output int low);
    load_data  = data;
    load_en    = 1'b1;
    move_valid = with_move;
    move_dir   = 2'd0;
    tick();
    load_en    = 1'b0;
    move_valid = 1'b0;
    low = 0;
    while (!move_ready && low < 30) begin
      low++;
      tick();
    end
  endtask

  task automatic issue_move(input logic [1:0] dir, output int low);
    move_valid = 1'b1;
    move_dir   = dir;
    tick();
    move_valid = 1'b0;
    move_dir   = ~dir;
    low = 0;
    while (!move_ready && low < 30) begin
      low++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; move_valid = 1'b0; load_en = 1'b0; move_dir = 2'd0; load_data = '0;
    tick(); tick();
    vectors++; if (game_state !== '0) begin miscompares++; $display("[TB] FAIL reset_board got %h want 0", game_state); end
    vectors++; if (score !== 20'd0) begin miscompares++; $display("[TB] FAIL reset_score got %0d want 0", score); end
    vectors++; if (move_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready got %b want 0", move_ready); end
    vectors++; if (game_won !== 1'b0 || game_over !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_flags got won=%b over=%b want 0 0", game_won, game_over); end
    reset = 1'b0;
    tick(); tick(); tick();
    vectors++; if (move_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL init_ready got %b want 1", move_ready); end
    vectors++; if (game_state !== init_board()) begin miscompares++; $display("[TB] FAIL init_board got %h want %h", game_state, init_board()); end
    vectors++; if (score !== 20'd0) begin miscompares++; $display("[TB] FAIL init_score got %0d want 0", score); end
  endtask

  task automatic test_merge_left();
    logic [191:0] b;
    int low;
    b = put(put(put(put('0, 0, 0, 12'd2), 0, 1, 12'd2), 0, 2, 12'd4), 0, 3, 12'd4);
    issue_load(b, 1'b1, low);
    vectors++; if (game_state !== b) begin miscompares++; $display("[TB] FAIL load_priority got %h want %h", game_state, b); end
    vectors++; if (low !== 1) begin miscompares++; $display("[TB] FAIL load_latency got %0d want 1", low); end
    issue_move(2'd0, low);
    exp_score += 12;
    vectors++; if (low !== 6) begin miscompares++; $display("[TB] FAIL left_latency got %0d want 6", low); end
    vectors++; if (tile(game_state, 0, 0) !== 12'd4 || tile(game_state, 0, 1) !== 12'd8) begin miscompares++; $display("[TB] FAIL left_row0 got %0d,%0d want 4,8", tile(game_state, 0, 0), tile(game_state, 0, 1)); end
    vectors++; if (nz_count(game_state) !== 3) begin miscompares++; $display("[TB] FAIL left_spawn_count got %0d want 3", nz_count(game_state)); end
    vectors++; if (tile_sum(game_state) != 14 && tile_sum(game_state) != 16) begin miscompares++; $display("[TB] FAIL left_spawn_value got sum %0d want 14 or 16", tile_sum(game_state)); end
    vectors++; if (score !== 20'(exp_score)) begin miscompares++; $display("[TB] FAIL left_score got %0d want %0d", score, exp_score); end
    vectors++; if (game_over !== 1'b0 || game_won !== 1'b0) begin miscompares++; $display("[TB] FAIL left_flags got won=%b over=%b want 0 0", game_won, game_over); end
  endtask

  task automatic test_merge_once();
    logic [191:0] b;
    int low;
    b = put(put(put(put('0, 0, 0, 12'd2), 0, 1, 12'd2), 0, 2, 12'd2), 0, 3, 12'd2);
    issue_load(b, 1'b0, low);
    issue_move(2'd1, low);
    exp_score += 8;
    vectors++; if (tile(game_state, 0, 2) !== 12'd4 || tile(game_state, 0, 3) !== 12'd4) begin miscompares++; $display("[TB] FAIL right_row0 got %0d,%0d want 4,4", tile(game_state, 0, 2), tile(game_state, 0, 3)); end
    vectors++; if (nz_count(game_state) !== 3 || (tile_sum(game_state) != 10 && tile_sum(game_state) != 12)) begin miscompares++; $display("[TB] FAIL right_spawn got count %0d sum %0d want 3 and 10/12", nz_count(game_state), tile_sum(game_state)); end
    vectors++; if (score !== 20'(exp_score)) begin miscompares++; $display("[TB] FAIL right_score got %0d want %0d", score, exp_score); end
    b = put(put('0, 0, 0, 12'd4), 3, 0, 12'd4);
    issue_load(b, 1'b0, low);
    issue_move(2'd2, low);
    exp_score += 8;
    vectors++; if (low !== 6) begin miscompares++; $display("[TB] FAIL up_latency got %0d want 6", low); end
    vectors++; if (tile(game_state, 0, 0) !== 12'd8) begin miscompares++; $display("[TB] FAIL up_col0 got %0d want 8", tile(game_state, 0, 0)); end
    vectors++; if (nz_count(game_state) !== 2 || (tile_sum(game_state) != 10 && tile_sum(game_state) != 12)) begin miscompares++; $display("[TB] FAIL up_spawn got count %0d sum %0d want 2 and 10/12", nz_count(game_state), tile_sum(game_state)); end
    vectors++; if (score !== 20'(exp_score)) begin miscompares++; $display("[TB] FAIL up_score got %0d want %0d", score, exp_score); end
  endtask

  task automatic test_no_change();
    logic [191:0] b;
    int low;
    b = put(put(put(put('0, 0, 0, 12'd2), 0, 1, 12'd4), 0, 2, 12'd8), 0, 3, 12'd16);
    issue_load(b, 1'b0, low);
    issue_move(2'd0, low);
    vectors++; if (low !== 4) begin miscompares++; $display("[TB] FAIL nochange_latency got %0d want 4", low); end
    vectors++; if (game_state !== b) begin miscompares++; $display("[TB] FAIL nochange_board got %h want %h", game_state, b); end
    issue_move(2'd2, low);
    vectors++; if (low !== 4 || game_state !== b) begin miscompares++; $display("[TB] FAIL nochange_up got latency %0d board %h want 4 %h", low, game_state, b); end
    vectors++; if (score !== 20'(exp_score)) begin miscompares++; $display("[TB] FAIL nochange_score got %0d want %0d", score, exp_score); end
  endtask

  task automatic test_win();
    logic [191:0] b;
    int low;
    b = put(put('0, 0, 0, 12'd1024), 0, 1, 12'd1024);
    issue_load(b, 1'b0, low);
    move_valid = 1'b1; move_dir = 2'd0;
    tick();
    move_valid = 1'b0;
    repeat (8) tick();
    exp_score += 2048;
    vectors++; if (game_won !== 1'b1 || move_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL win_flags got won=%b ready=%b want 1 0", game_won, move_ready); end
    vectors++; if (tile(game_state, 0, 0) !== 12'd2048) begin miscompares++; $display("[TB] FAIL win_tile got %0d want 2048", tile(game_state, 0, 0)); end
    vectors++; if (score !== 20'(exp_score)) begin miscompares++; $display("[TB] FAIL win_score got %0d want %0d", score, exp_score); end
    for (int i = 0; i < 3; i++) begin
      move_valid = 1'b1; move_dir = 2'd3; load_en = 1'b1; load_data = '0;
      tick();
      move_valid = 1'b0; load_en = 1'b0;
      tick();
    end
    repeat (6) tick();
    vectors++; if (tile(game_state, 0, 0) !== 12'd2048 || nz_count(game_state) !== 2 || (tile_sum(game_state) != 2050 && tile_sum(game_state) != 2052)) begin miscompares++; $display("[TB] FAIL win_terminal got tile %0d count %0d sum %0d want 2048 2 2050/2052", tile(game_state, 0, 0), nz_count(game_state), tile_sum(game_state)); end
    vectors++; if (move_ready !== 1'b0 || game_won !== 1'b1) begin miscompares++; $display("[TB] FAIL win_sticky got ready=%b won=%b want 0 1", move_ready, game_won); end
  endtask

  task automatic test_game_over();
    logic [191:0] chk;
    chk = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk = put(chk, r, c, ((r + c) % 2 == 0) ? 12'd2 : 12'd4);
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    repeat (3) tick();
    vectors++; if (move_ready !== 1'b1 || score !== 20'd0) begin miscompares++; $display("[TB] FAIL over_start got ready=%b score=%0d want 1 0", move_ready, score); end
    load_data = chk; load_en = 1'b1;
    tick();
    load_en = 1'b0;
    tick();
    vectors++; if (game_over !== 1'b1 || game_won !== 1'b0) begin miscompares++; $display("[TB] FAIL over_flags got over=%b won=%b want 1 0", game_over, game_won); end
    vectors++; if (game_state !== chk) begin miscompares++; $display("[TB] FAIL over_board got %h want %h", game_state, chk); end
    load_data = '0; load_en = 1'b1; move_valid = 1'b1; move_dir = 2'd0;
    tick();
    load_en = 1'b0; move_valid = 1'b0;
    repeat (6) tick();
    vectors++; if (game_state !== chk || move_ready !== 1'b0 || game_over !== 1'b1) begin miscompares++; $display("[TB] FAIL over_terminal got ready=%b over=%b board %h want 0 1 %h", move_ready, game_over, game_state, chk); end
  endtask

  task automatic test_reset_mid_move();
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (3) tick();
    move_valid = 1'b1; move_dir = 2'd0;
    tick();
    move_valid = 1'b0;
    tick();
    vectors++; if (tile(game_state, 0, 0) !== 12'd4) begin miscompares++; $display("[TB] FAIL midmove_row0 got %0d want 4", tile(game_state, 0, 0)); end
    reset = 1'b1;
    tick();
    vectors++; if (game_state !== '0 || score !== 20'd0) begin miscompares++; $display("[TB] FAIL midmove_reset got board %h score %0d want 0 0", game_state, score); end
    vectors++; if (move_ready !== 1'b0 || game_over !== 1'b0 || game_won !== 1'b0) begin miscompares++; $display("[TB] FAIL midmove_flags got ready=%b over=%b won=%b want 0 0 0", move_ready, game_over, game_won); end
    reset = 1'b0;
    repeat (3) tick();
    vectors++; if (game_state !== init_board() || move_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reinit_board got %h ready=%b want %h 1", game_state, move_ready, init_board()); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_merge_left();
    test_merge_once();
    test_no_change();
    test_win();
    test_game_over();
    test_reset_mid_move();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
